// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//
// Shares the single register-file write port between the pipeline writeback
// stage and a multi-cycle unit (MDU). Pipeline writes always win and pass
// straight through with zero latency. MDU results wait in a small in-order
// FIFO and drain whenever the port is free. A buffered result whose
// destination is overwritten by a (younger) pipeline write is killed and
// later popped without a write. If the FIFO head is blocked for
// STARVE_LIMIT cycles, a registered bubble request is raised upstream.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   pipe_we_i/rd_i/wdata_i     WB stage write request (never delayed)
//   mdu_valid_i/rd_i/wdata_i   MDU result offer
//   mdu_ready_o                FIFO has room (state only, no bypass)
//   rf_we_o/waddr_o/wdata_o    register-file write port
//   hz_rs1_i/hz_rs2_i          hazard query registers
//   hz_rs1_busy_o/rs2_busy_o   query matches a valid buffered result
//   stall_req_o                registered request for one writeback bubble
// -----------------------------------------------------------------------------
module wb_port_arbiter #(
  parameter int FIFO_DEPTH   = 2,  // power of 2, >= 2
  parameter int STARVE_LIMIT = 4   // 1..15
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        pipe_we_i,
  input  logic [4:0]  pipe_rd_i,
  input  logic [31:0] pipe_wdata_i,

  input  logic        mdu_valid_i,
  input  logic [4:0]  mdu_rd_i,
  input  logic [31:0] mdu_wdata_i,
  output logic        mdu_ready_o,

  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,

  input  logic [4:0]  hz_rs1_i,
  input  logic [4:0]  hz_rs2_i,
  output logic        hz_rs1_busy_o,
  output logic        hz_rs2_busy_o,

  output logic        stall_req_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [3:0]    LIMIT_C = 4'(STARVE_LIMIT);

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [FIFO_DEPTH-1:0] ent_valid;
  logic [4:0]            ent_rd   [FIFO_DEPTH];
  logic [31:0]           ent_data [FIFO_DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;       // includes killed entries
  logic [3:0]    starve_cnt;

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  logic port_busy;
  logic fifo_empty;
  logic head_valid;
  logic head_write;
  logic pop;
  logic accept;
  logic push;
  logic push_valid;

  always_comb begin
    port_busy  = pipe_we_i && (pipe_rd_i != 5'd0);
    fifo_empty = (count == '0);
    head_valid = !fifo_empty && ent_valid[rd_ptr];
    head_write = head_valid && !port_busy;
    // A killed head leaves regardless of the port; a live head only when free.
    pop        = !fifo_empty && (!ent_valid[rd_ptr] || !port_busy);

    mdu_ready_o = (count < DEPTH_C);
    accept      = mdu_valid_i && mdu_ready_o;
    // rd=0 results are accepted but never stored.
    push        = accept && (mdu_rd_i != 5'd0);
    // The pipe write this cycle is younger, so a same-rd result arrives dead.
    push_valid  = !(port_busy && (mdu_rd_i == pipe_rd_i));
  end

  // ---------------------------------------------------------------------------
  // Register-file write mux
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default first so no path through this block
    // leaves a value unassigned, which would otherwise infer a latch.
    rf_we_o    = 1'b0;
    rf_waddr_o = 5'd0;
    rf_wdata_o = 32'd0;
    if (port_busy) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = pipe_rd_i;
      rf_wdata_o = pipe_wdata_i;
    end else if (head_write) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = ent_rd[rd_ptr];
      rf_wdata_o = ent_data[rd_ptr];
    end else if (pipe_we_i) begin
      // A write to x0 with nothing to drain simply follows the pipe inputs.
      rf_we_o    = 1'b1;
      rf_waddr_o = pipe_rd_i;
      rf_wdata_o = pipe_wdata_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Hazard query: only stored, still-valid entries count. Popped slots have
  // their valid bit cleared, so scanning every slot is exact.
  // ---------------------------------------------------------------------------
  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit = 1'b0;
    rs2_hit = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (ent_valid[i] && (ent_rd[i] == hz_rs1_i)) rs1_hit = 1'b1;
      if (ent_valid[i] && (ent_rd[i] == hz_rs2_i)) rs2_hit = 1'b1;
    end
    hz_rs1_busy_o = rs1_hit && (hz_rs1_i != 5'd0);
    hz_rs2_busy_o = rs2_hit && (hz_rs2_i != 5'd0);
  end

  // ---------------------------------------------------------------------------
  // FIFO control state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order across blocks.
    if (!rst_n) begin
      ent_valid <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      // Kill first; pop and push below override their own slot afterwards.
      if (port_busy) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
          if (ent_rd[i] == pipe_rd_i) ent_valid[i] <= 1'b0;
        end
      end
      if (pop) begin
        ent_valid[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + AW'(1);
      end
      // When push is possible the FIFO is not full, so wr_ptr != rd_ptr
      // whenever pop is also active; the two slot updates never collide.
      if (push) begin
        ent_valid[wr_ptr] <= push_valid;
        wr_ptr            <= wr_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the payload array is deliberately not reset; it is only ever
  // observed through a set valid bit, so resetting it would buy nothing.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_rd[wr_ptr]   <= mdu_rd_i;
      ent_data[wr_ptr] <= mdu_wdata_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Starvation tracking and bubble request
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt  <= 4'd0;
      stall_req_o <= 1'b0;
    end else begin
      if (fifo_empty || pop) begin
        starve_cnt <= 4'd0;
      end else if (head_valid && port_busy && (starve_cnt != LIMIT_C)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
      stall_req_o <= (starve_cnt == LIMIT_C);
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_port_arbiter
//
// Drives directed scenarios followed by constrained-random traffic. A queue
// based model of the writeback port predicts every output each cycle; a few
// literal expectations in the directed part pin the model itself.
// -----------------------------------------------------------------------------
module tb_wb_port_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk;
  logic        rst_n;
  logic        pipe_we_i;
  logic [4:0]  pipe_rd_i;
  logic [31:0] pipe_wdata_i;
  logic        mdu_valid_i;
  logic [4:0]  mdu_rd_i;
  logic [31:0] mdu_wdata_i;
  logic        mdu_ready_o;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic [4:0]  hz_rs1_i;
  logic [4:0]  hz_rs2_i;
  logic        hz_rs1_busy_o;
  logic        hz_rs2_busy_o;
  logic        stall_req_o;

  wb_port_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pipe_we_i     (pipe_we_i),
    .pipe_rd_i     (pipe_rd_i),
    .pipe_wdata_i  (pipe_wdata_i),
    .mdu_valid_i   (mdu_valid_i),
    .mdu_rd_i      (mdu_rd_i),
    .mdu_wdata_i   (mdu_wdata_i),
    .mdu_ready_o   (mdu_ready_o),
    .rf_we_o       (rf_we_o),
    .rf_waddr_o    (rf_waddr_o),
    .rf_wdata_o    (rf_wdata_o),
    .hz_rs1_i      (hz_rs1_i),
    .hz_rs2_i      (hz_rs2_i),
    .hz_rs1_busy_o (hz_rs1_busy_o),
    .hz_rs2_busy_o (hz_rs2_busy_o),
    .stall_req_o   (stall_req_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vectors    = 0;
  int n_miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: an ordered list of buffered results plus a count of
  // consecutive cycles the oldest live result has been blocked.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit        live;
    bit [4:0]  rd;
    bit [31:0] data;
  } ent_t;

  ent_t q[$];
  int   blocked = 0;
  bit   stall_m = 0;

  // One clock cycle: apply inputs just after the rising edge, compare all
  // outputs on the falling edge, then advance the model across the next edge.
  task automatic cyc(input bit rst, input bit pwe, input bit [4:0] prd, input bit [31:0] pwd,
                     input bit mv, input bit [4:0] mrd, input bit [31:0] mwd,
                     input bit [4:0] r1, input bit [4:0] r2);
    bit        busy, ready_e, we_e, h1, h2, pop;
    bit [4:0]  wa_e;
    bit [31:0] wd_e;
    @(posedge clk);
    #1;
    rst_n        = rst;
    pipe_we_i    = pwe;
    pipe_rd_i    = prd;
    pipe_wdata_i = pwd;
    mdu_valid_i  = mv;
    mdu_rd_i     = mrd;
    mdu_wdata_i  = mwd;
    hz_rs1_i     = r1;
    hz_rs2_i     = r2;
    if (!rst) begin
      q.delete();
      blocked = 0;
      stall_m = 0;
    end

    busy    = pwe && (prd != 0);
    ready_e = (q.size() < DEPTH);
    we_e = 0; wa_e = 0; wd_e = 0;
    if (busy || (pwe && !(q.size() > 0 && q[0].live))) begin
      we_e = 1; wa_e = prd; wd_e = pwd;
    end else if (q.size() > 0 && q[0].live) begin
      we_e = 1; wa_e = q[0].rd; wd_e = q[0].data;
    end
    h1 = 0; h2 = 0;
    foreach (q[i]) begin
      if (q[i].live && q[i].rd == r1 && r1 != 0) h1 = 1;
      if (q[i].live && q[i].rd == r2 && r2 != 0) h2 = 1;
    end

    @(negedge clk);
    check("rf_we",    32'(rf_we_o),       32'(we_e));
    check("rf_waddr", 32'(rf_waddr_o),    32'(wa_e));
    check("rf_wdata", rf_wdata_o,         wd_e);
    check("ready",    32'(mdu_ready_o),   32'(ready_e));
    check("hz1",      32'(hz_rs1_busy_o), 32'(h1));
    check("hz2",      32'(hz_rs2_busy_o), 32'(h2));
    check("stall",    32'(stall_req_o),   32'(stall_m));

    if (rst) begin
      pop     = (q.size() > 0) && (!q[0].live || !busy);
      stall_m = (blocked == LIMIT);
      if (q.size() == 0 || pop) blocked = 0;
      else if (blocked < LIMIT) blocked++;
      if (busy) foreach (q[i]) if (q[i].rd == prd) q[i].live = 0;
      if (pop) void'(q.pop_front());
      if (mv && ready_e && mrd != 0) q.push_back('{!(busy && mrd == prd), mrd, mwd});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  bit        r_rst, r_pwe, r_mv;
  bit [4:0]  r_prd, r_mrd, r_r1, r_r2;
  bit [31:0] r_pwd, r_mwd;

  initial begin
    rst_n = 0; pipe_we_i = 0; pipe_rd_i = 0; pipe_wdata_i = 0;
    mdu_valid_i = 0; mdu_rd_i = 0; mdu_wdata_i = 0; hz_rs1_i = 0; hz_rs2_i = 0;

    // Reset state; rf follows pipe inputs while in reset.
    cyc(0, 1, 5'd9, 32'hCAFE, 1, 5'd2, 32'h1, 5'd2, 5'd0);
    check("rst_rf_we", 32'(rf_we_o), 32'd1);
    check("rst_rf_waddr", 32'(rf_waddr_o), 32'd9);
    check("rst_ready", 32'(mdu_ready_o), 32'd1);
    check("rst_stall", 32'(stall_req_o), 32'd0);
    idle(2);

    // Single result drains the cycle after acceptance.
    cyc(1, 0, 0, 0, 1, 5'd5, 32'h1234, 5'd5, 0);
    check("d1_ready", 32'(mdu_ready_o), 32'd1);
    check("d1_we0",   32'(rf_we_o), 32'd0);
    check("d1_hz0",   32'(hz_rs1_busy_o), 32'd0);
    cyc(1, 0, 0, 0, 0, 0, 0, 5'd5, 0);
    check("d1_we1",   32'(rf_we_o), 32'd1);
    check("d1_waddr", 32'(rf_waddr_o), 32'd5);
    check("d1_wdata", rf_wdata_o, 32'h1234);
    check("d1_hz1",   32'(hz_rs1_busy_o), 32'd1);
    cyc(1, 0, 0, 0, 0, 0, 0, 5'd5, 0);
    check("d1_hz2",   32'(hz_rs1_busy_o), 32'd0);
    idle(1);

    // Pipe hogs the port: FIFO fills, head starves, bubble drains it.
    cyc(1, 1, 5'd3, 32'h30, 1, 5'd7, 32'h70, 0, 0);
    cyc(1, 1, 5'd3, 32'h31, 1, 5'd8, 32'h80, 0, 0);
    cyc(1, 1, 5'd3, 32'h32, 1, 5'd9, 32'h90, 0, 0);
    check("d2_full_ready", 32'(mdu_ready_o), 32'd0);
    cyc(1, 1, 5'd3, 32'h33, 1, 5'd9, 32'h90, 0, 0);
    cyc(1, 1, 5'd3, 32'h34, 1, 5'd9, 32'h90, 0, 0);
    cyc(1, 1, 5'd3, 32'h35, 1, 5'd9, 32'h90, 0, 0);
    check("d2_stall_lo", 32'(stall_req_o), 32'd0);
    cyc(1, 0, 0, 0, 1, 5'd9, 32'h90, 0, 0);
    check("d2_stall_hi", 32'(stall_req_o), 32'd1);
    check("d2_drain_addr", 32'(rf_waddr_o), 32'd7);
    check("d2_drain_data", rf_wdata_o, 32'h70);
    cyc(1, 0, 0, 0, 1, 5'd9, 32'h90, 0, 0);
    idle(4);

    // Kill: pipe overwrites a buffered destination.
    cyc(1, 0, 0, 0, 1, 5'd4, 32'h44, 0, 0);
    cyc(1, 1, 5'd4, 32'hAA, 0, 0, 0, 5'd4, 0);
    check("d3_pipe_addr", 32'(rf_waddr_o), 32'd4);
    check("d3_pipe_data", rf_wdata_o, 32'hAA);
    cyc(1, 0, 0, 0, 0, 0, 0, 5'd4, 0);
    check("d3_no_write", 32'(rf_we_o), 32'd0);
    check("d3_hz_clear", 32'(hz_rs1_busy_o), 32'd0);
    idle(1);

    // rd=0 result discarded; rd=0 pipe write does not block a drain.
    cyc(1, 0, 0, 0, 1, 5'd0, 32'h77, 0, 0);
    cyc(1, 0, 0, 0, 1, 5'd6, 32'h66, 0, 0);
    check("d4_no_write", 32'(rf_we_o), 32'd0);
    check("d4_ready", 32'(mdu_ready_o), 32'd1);
    cyc(1, 1, 5'd0, 32'h99, 0, 0, 0, 0, 0);
    check("d4_drain_addr", 32'(rf_waddr_o), 32'd6);
    check("d4_drain_data", rf_wdata_o, 32'h66);
    idle(1);

    // Full FIFO: no same-cycle bypass while the head drains.
    cyc(1, 1, 5'd3, 0, 1, 5'd10, 32'hA0, 0, 0);
    cyc(1, 1, 5'd3, 0, 1, 5'd11, 32'hB0, 0, 0);
    cyc(1, 0, 0, 0, 1, 5'd12, 32'hC0, 0, 0);
    check("d5_ready_full", 32'(mdu_ready_o), 32'd0);
    check("d5_drain", 32'(rf_waddr_o), 32'd10);
    cyc(1, 0, 0, 0, 1, 5'd12, 32'hC0, 0, 0);
    check("d5_ready_next", 32'(mdu_ready_o), 32'd1);
    cyc(1, 0, 0, 0, 0, 0, 0, 5'd12, 0);
    check("d5_last", 32'(rf_waddr_o), 32'd12);
    idle(2);

    // Reset with two entries buffered discards them.
    cyc(1, 1, 5'd3, 0, 1, 5'd13, 32'hD0, 0, 0);
    cyc(1, 1, 5'd3, 0, 1, 5'd14, 32'hE0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 5'd13, 5'd14);
    check("d6_ready", 32'(mdu_ready_o), 32'd1);
    check("d6_hz", 32'(hz_rs1_busy_o), 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("d6_no_write", 32'(rf_we_o), 32'd0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("d6_no_write2", 32'(rf_we_o), 32'd0);

    // Random traffic over a small register range to force collisions.
    for (int n = 0; n < 3000; n++) begin
      r_rst = ($urandom_range(0, 199) != 0);
      r_pwe = stall_m ? 1'b0 : ($urandom_range(0, 9) < 6);
      r_prd = 5'($urandom_range(0, 7));
      r_pwd = $urandom();
      r_mv  = ($urandom_range(0, 1) == 1);
      r_mrd = 5'($urandom_range(0, 7));
      r_mwd = $urandom();
      r_r1  = 5'($urandom_range(0, 7));
      r_r2  = 5'($urandom_range(0, 7));
      cyc(r_rst, r_pwe, r_prd, r_pwd, r_mv, r_mrd, r_mwd, r_r1, r_r2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter: FIFO_DEPTH, default 2, number of buffered multi-cycle-unit results (power of 2, >=2).
REQ-002 Parameter: STARVE_LIMIT, default 4, consecutive blocked cycles before a pipeline bubble is requested (1..15).
REQ-003 The block SHALL use one clock and an asynchronous active-low reset:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous reset, active low.
REQ-004 Pipeline writeback inputs, driven by the WB stage:
- pipe_we_i  in  1  WB stage register write request.
- pipe_rd_i  in  5  WB destination register.
- pipe_wdata_i  in  32  WB write data.
REQ-005 Multi-cycle unit (MDU) result port, valid/ready handshake:
- mdu_valid_i  in  1  result offered.
- mdu_rd_i  in  5  result destination.
- mdu_wdata_i  in  32  result data.
- mdu_ready_o  out  1  result accepted this cycle when high with mdu_valid_i.
REQ-006 Register-file write port:
- rf_we_o  out  1  write enable.
- rf_waddr_o  out  5  write address.
- rf_wdata_o  out  32  write data.
REQ-007 Hazard query:
- hz_rs1_i  in  5  source register 1 query.
- hz_rs2_i  in  5  source register 2 query.
- hz_rs1_busy_o  out  1  rs1 has a pending buffered write.
- hz_rs2_busy_o  out  1  rs2 has a pending buffered write.
REQ-008 stall_req_o  out  1  registered request for upstream to inject one writeback bubble.

Function
REQ-009 "Port busy" SHALL be defined as pipe_we_i=1 and pipe_rd_i!=0; pipe writes are never delayed and pass to rf_* combinationally with zero latency.
REQ-010 MDU results SHALL be held in an in-order FIFO of FIFO_DEPTH entries {valid, rd, data}; count includes killed entries.
REQ-011 mdu_ready_o SHALL equal (count<FIFO_DEPTH), combinational from state only; there is no same-cycle bypass when full.
REQ-012 On accept (mdu_valid_i & mdu_ready_o): rd=0 -> accepted and discarded; otherwise enqueued with valid=1, except valid=0 if port busy and mdu_rd_i=pipe_rd_i.
REQ-013 Kill: each cycle the port is busy, every stored entry with rd=pipe_rd_i SHALL have valid cleared at the clock edge; the pipe write is defined as younger than all buffered results.
REQ-014 Drain: if the head is valid and the port is not busy, rf_* SHALL present the head and the head SHALL pop; if the head is killed, it SHALL pop without a write in any cycle.
REQ-015 Simultaneous accept and pop in one cycle SHALL leave count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-016 When neither pipe nor head writes, rf_we_o=0; rf_waddr_o and rf_wdata_o SHALL then be 0.
REQ-017 Starve counter: increments (saturating at STARVE_LIMIT) each cycle the head is valid and the port is busy; clears on any pop or when the FIFO is empty.
REQ-018 stall_req_o SHALL be the counter==STARVE_LIMIT condition registered one cycle later; upstream guarantees pipe_we_i=0 in the cycle after stall_req_o=1, and the head drains then.
REQ-019 hz_rsN_busy_o SHALL be 1 iff hz_rsN_i!=0 and it matches rd of any valid stored entry; this is combinational, and incoming un-accepted results are excluded.

Reset
REQ-020 While rst_n=0: FIFO empty, all valid bits 0, pointers and counter 0, stall_req_o=0, mdu_ready_o=1, hz busy outputs 0, and rf_* follow the pipe inputs only.
REQ-021 Reset assertion mid-operation SHALL discard all buffered results without writing them.

Verification
REQ-022 Pipe idle, MDU offers rd=5 data=0x1234 -> accepted at cycle 0; rf_we_o=1, waddr=5, wdata=0x1234 at cycle 1; hz busy for rs1=5 is high only during cycle 1.
REQ-023 Pipe writes rd=3 every cycle while MDU offers rd=7, rd=8, rd=9 -> first two accepted; mdu_ready_o=0 on the third; after 4 blocked cycles stall_req_o=1; next idle cycle writes rd=7.
REQ-024 FIFO holds rd=4 (valid); pipe writes rd=4 data=0xAA -> entry killed; next idle cycle issues no rf write for it; hz_rs1_busy_o(4)=0 after the edge.
REQ-025 MDU offers rd=0 -> accepted, count stays 0, no rf write; pipe write with rd=0 does not block a drain.
REQ-026 FIFO full, head drains the same cycle as a new offer -> offer not accepted (ready=0), accepted next cycle; count never exceeds 2.
REQ-027 rst_n pulled low with 2 entries buffered -> mdu_ready_o=1, stall_req_o=0, and no rf write for the discarded entries after release.
